// File: rtl/regfile_sb_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_param_if
//  Brief    : Read, write, reserve and status bundle of the scoreboarded register file.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_sb_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy1;
  logic              busy2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              ready;

  modport master (
    output raddr1, raddr2, we, waddr, wdata, rsv_en, rsv_addr,
    input  rdata1, rdata2, busy1, busy2, ready
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata, rsv_en, rsv_addr,
    output rdata1, rdata2, busy1, busy2, ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb_param.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_param
//  Brief    : 2R/1W register file with busy scoreboard and post-reset clear
//             sweep. Define REGFILE_BYPASS_EN to forward same-cycle writes.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sb_param_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run_w;
  logic wr_ok_w;
  logic rsv_ok_w;

  assign run_w    = (state_q == ST_RUN);
  assign wr_ok_w  = run_w && bus.we     && (bus.waddr    != '0);
  assign rsv_ok_w = run_w && bus.rsv_en && (bus.rsv_addr != '0);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (&clr_ptr_q) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Reserve is applied after release so a same-edge write+reserve leaves the entry busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_w)  busy_d[bus.waddr]    = 1'b0;
    if (rsv_ok_w) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok_w) begin
        mem_q[bus.waddr] <= bus.wdata;
      end
    end
  end

  logic [ADDR_W-1:0] raddr_w [2];
  assign raddr_w[0] = bus.raddr1;
  assign raddr_w[1] = bus.raddr2;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [DATA_W-1:0] data_c;
      logic              busy_c;
      always_comb begin
        data_c = '0;
        busy_c = 1'b0;
        if (run_w && (raddr_w[p] != '0)) begin
          data_c = mem_q[raddr_w[p]];
          busy_c = busy_q[raddr_w[p]];
          if (BYPASS && wr_ok_w && (raddr_w[p] == bus.waddr)) begin
            data_c = bus.wdata;
            busy_c = 1'b0;
          end
        end
      end
    end
  endgenerate

  assign bus.rdata1 = g_rd[0].data_c;
  assign bus.busy1  = g_rd[0].busy_c;
  assign bus.rdata2 = g_rd[1].data_c;
  assign bus.busy2  = g_rd[1].busy_c;
  assign bus.ready  = run_w;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb_param
//  Brief    : Self-checking bench for regfile_sb_param with a reference model
//             and an expected-value queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb_param;

  logic clk;
  logic rst;

  regfile_sb_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic        m_ready;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_read(input logic [4:0] a, input logic we_,
                                             input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] d;
    logic        b;
    d = 32'h0;
    b = 1'b0;
    if (m_ready && a != 5'd0) begin
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we_ && wa != 5'd0 && wa == a) begin
        d = wd;
        b = 1'b0;
      end
`endif
    end
    return {b, d};
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, take the edge, update the model.
  task automatic cyc(input logic r, input logic we_, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rs, input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2);
    logic [32:0] e1, e2;
    exp_t        ent;
    logic [31:0] obs [5];
    rst          = r;
    bus.we       = we_;
    bus.waddr    = wa;
    bus.wdata    = wd;
    bus.rsv_en   = rs;
    bus.rsv_addr = ra;
    bus.raddr1   = a1;
    bus.raddr2   = a2;
    e1 = model_read(a1, we_, wa, wd);
    e2 = model_read(a2, we_, wa, wd);
    sb_q.push_back('{tag: $sformatf("rdata1[%0d]", a1), exp: e1[31:0]});
    sb_q.push_back('{tag: $sformatf("busy1[%0d]", a1),  exp: {31'h0, e1[32]}});
    sb_q.push_back('{tag: $sformatf("rdata2[%0d]", a2), exp: e2[31:0]});
    sb_q.push_back('{tag: $sformatf("busy2[%0d]", a2),  exp: {31'h0, e2[32]}});
    sb_q.push_back('{tag: "ready",                      exp: {31'h0, m_ready}});
    #1;
    obs[0] = bus.rdata1;
    obs[1] = {31'h0, bus.busy1};
    obs[2] = bus.rdata2;
    obs[3] = {31'h0, bus.busy2};
    obs[4] = {31'h0, bus.ready};
    for (int k = 0; k < 5; k++) begin
      ent = sb_q.pop_front();
      check_eq(ent.tag, obs[k], ent.exp);
    end
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end else begin
      if (we_ && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rs && ra != 5'd0) m_busy[ra] = 1'b1;
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a1, a2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.raddr1 = '0; bus.raddr2 = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held for three cycles, then the 32-cycle sweep; writes/reserves must be ignored.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    for (int i = 0; i < 32; i++) begin
      if (i == 20) cyc(1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd4, 5'd6);
      else         idle(5'(i), 5'(31 - i));
    end
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // Write then read; write to r0 has no effect.
    cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    idle(5'd5, 5'd0);
    cyc(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Reserve, release by write, reserve of r0.
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    cyc(1'b0, 1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd7);

    // Same-edge write and reserve: data lands, busy stays set.
    cyc(1'b0, 1'b1, 5'd9, 32'h0000_00A5, 1'b1, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9);

    // Same-cycle read of the register being written (forwarding case).
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    cyc(1'b0, 1'b1, 5'd3, 32'h0000_0077, 1'b0, 5'd0, 5'd3, 5'd4);
    idle(5'd3, 5'd3);

    // Mixed random traffic over a small register window to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    // r2 busy, then reset in RUN, reset again at clr_ptr=10, then a full sweep.
    cyc(1'b0, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd2, 5'd2, 5'd2);
    idle(5'd2, 5'd2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
    for (int i = 0; i < 10; i++) idle(5'd2, 5'd5);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
    for (int i = 0; i < 32; i++) idle(5'd2, 5'(i));
    for (int i = 0; i < 32; i++) idle(5'(i), 5'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
